// File: rtl/wishbone_master_adapter_cpu.sv
// Wishbone classic master adapter for the RV32I data-memory port.
// A single-cycle CPU request becomes one Wishbone cycle. CYC/STB are held until
// ACK arrives or the watchdog expires. Completion is signalled by a one-cycle
// rvalid pulse that carries read data and a timeout error flag.
`timescale 1ns/1ps
module wishbone_master_adapter_cpu #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  // CPU side
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              cpu_we_i,
  input  logic [3:0]        cpu_sel_i,
  output logic              cpu_busy_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_err_o,
  // Wishbone side
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value at which a still-unacknowledged access is aborted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;

  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] wdata_next;
  logic              we_next;
  logic [3:0]        sel_next;
  logic              stb_next;
  logic              cyc_next;
  logic              rvalid_next;
  logic [DATA_W-1:0] rdata_next;
  logic              err_next;

  // Busy decodes straight from the state register so it drops with reset at once.
  assign cpu_busy_o = (state != IDLE);

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-output logic; every target holds its value unless a case overrides it.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    addr_next   = wb_addr_o;
    wdata_next  = wb_data_o;
    we_next     = wb_we_o;
    sel_next    = wb_sel_o;
    stb_next    = wb_stb_o;
    cyc_next    = wb_cyc_o;
    rvalid_next = cpu_rvalid_o;
    rdata_next  = cpu_rdata_o;
    err_next    = cpu_err_o;

    unique case (state)
      IDLE: begin
        rvalid_next = 1'b0;
        err_next    = 1'b0;
        if (cpu_req_i) begin
          // Latch the whole request into the bus-facing registers.
          addr_next  = cpu_addr_i;
          wdata_next = cpu_wdata_i;
          we_next    = cpu_we_i;
          sel_next   = cpu_sel_i;
          stb_next   = 1'b1;
          cyc_next   = 1'b1;
          cnt_next   = '0;
          state_next = BUS;
        end
      end

      BUS: begin
        if (wb_ack_i) begin
          // ACK takes priority over a timeout on the same edge.
          rdata_next  = wb_we_o ? '0 : wb_data_i;
          stb_next    = 1'b0;
          cyc_next    = 1'b0;
          we_next     = 1'b0;
          rvalid_next = 1'b1;
          err_next    = 1'b0;
          state_next  = DONE;
        end else if (cnt == CNT_LAST) begin
          // Watchdog expired: abandon the cycle and report an error.
          rdata_next  = '0;
          stb_next    = 1'b0;
          cyc_next    = 1'b0;
          rvalid_next = 1'b1;
          err_next    = 1'b1;
          state_next  = DONE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        // Single completion cycle; also gives the slave its post-ACK cooldown.
        rvalid_next = 1'b0;
        err_next    = 1'b0;
        state_next  = IDLE;
      end

      default: begin
        stb_next    = 1'b0;
        cyc_next    = 1'b0;
        rvalid_next = 1'b0;
        err_next    = 1'b0;
        state_next  = IDLE;
      end
    endcase
  end

  // Registered datapath: bus outputs, CPU response and watchdog counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt          <= '0;
      wb_addr_o    <= '0;
      wb_data_o    <= '0;
      wb_we_o      <= 1'b0;
      wb_sel_o     <= 4'h0;
      wb_stb_o     <= 1'b0;
      wb_cyc_o     <= 1'b0;
      cpu_rvalid_o <= 1'b0;
      cpu_rdata_o  <= '0;
      cpu_err_o    <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      wb_addr_o    <= addr_next;
      wb_data_o    <= wdata_next;
      wb_we_o      <= we_next;
      wb_sel_o     <= sel_next;
      wb_stb_o     <= stb_next;
      wb_cyc_o     <= cyc_next;
      cpu_rvalid_o <= rvalid_next;
      cpu_rdata_o  <= rdata_next;
      cpu_err_o    <= err_next;
    end
  end

endmodule

// File: tb/tb_wishbone_master_adapter_cpu.sv
// Randomized scoreboard bench for wishbone_master_adapter_cpu with a behavioural slave.
`timescale 1ns/1ps
module tb_wishbone_master_adapter_cpu;

  localparam int T = 8;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cpu_req_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic        cpu_busy_o;
  logic        cpu_rvalid_o;
  logic [31:0] cpu_rdata_o;
  logic        cpu_err_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  wishbone_master_adapter_cpu #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T), .CNT_W(8)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_busy_o(cpu_busy_o),
    .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o), .cpu_err_o(cpu_err_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // One transaction as issued; delay = BUS cycle in which the slave raises ACK (0 = never).
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sel;
    int          delay;
    logic [31:0] sdata;
    int          req_edge;
  } txn_t;

  txn_t        expq[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          cycle  = 0;
  int          slave_delay = 0;
  logic [31:0] slave_data  = '0;
  int          rise_prev = -1;
  int          rise_last = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // Edge counter: after rising edge E, cycle == E.
  initial forever begin
    @(posedge clk_i);
    cycle++;
  end

  // Slave model: ACK in the configured BUS cycle with the configured data;
  // stray random ACKs and junk data whenever no cycle is open.
  initial begin
    int scnt;
    scnt = 0;
    wb_ack_i  = 1'b0;
    wb_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (wb_cyc_o && wb_stb_o) begin
        scnt++;
        wb_ack_i  = (scnt == slave_delay);
        wb_data_i = (scnt == slave_delay) ? slave_data : $urandom;
      end else begin
        scnt = 0;
        wb_ack_i  = ($urandom_range(0, 2) == 0);
        wb_data_i = $urandom;
      end
    end
  end

  // Monitor: checks bus activity and completions against the queued transactions.
  initial begin
    bit   prev_cyc, prev_rvalid, exp_err;
    txn_t t;
    int   done_edge;
    logic [31:0] exp_rdata;
    prev_cyc = 0;
    prev_rvalid = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        prev_cyc = 0;
        prev_rvalid = 0;
      end else begin
        if (prev_rvalid) begin
          chk("busy_after_done", {31'd0, cpu_busy_o}, 32'd0);
          chk("rvalid_one_cycle", {31'd0, cpu_rvalid_o}, 32'd0);
        end
        if (wb_cyc_o) begin
          if (expq.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_cyc: got cyc=1, expected no bus cycle (cycle %0d)", cycle);
          end else begin
            t = expq[0];
            if (!prev_cyc) begin
              chk("cyc_rise_time", cycle, t.req_edge);
              rise_prev = rise_last;
              rise_last = cycle;
            end
            chk("wb_addr", wb_addr_o, t.addr);
            chk("wb_data", wb_data_o, t.wdata);
            chk("wb_we", {31'd0, wb_we_o}, {31'd0, t.we});
            chk("wb_sel", {28'd0, wb_sel_o}, {28'd0, t.sel});
            chk("wb_stb", {31'd0, wb_stb_o}, 32'd1);
          end
        end
        if (cpu_rvalid_o) begin
          if (expq.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_rvalid: got rvalid=1, expected none (cycle %0d)", cycle);
          end else begin
            t = expq.pop_front();
            exp_err   = (t.delay == 0) || (t.delay > T);
            exp_rdata = (exp_err || t.we) ? 32'd0 : t.sdata;
            done_edge = t.req_edge + (exp_err ? T : t.delay);
            chk("rvalid_time", cycle, done_edge);
            chk("err", {31'd0, cpu_err_o}, {31'd0, exp_err});
            chk("rdata", cpu_rdata_o, exp_rdata);
            chk("cyc_low_at_done", {31'd0, wb_cyc_o}, 32'd0);
            chk("stb_low_at_done", {31'd0, wb_stb_o}, 32'd0);
            if (!exp_err) chk("we_cleared", {31'd0, wb_we_o}, 32'd0);
          end
        end
        prev_cyc    = wb_cyc_o;
        prev_rvalid = cpu_rvalid_o;
      end
    end
  end

  // Wait (from a negedge) until the adapter is idle, wiggling junk requests meanwhile.
  task automatic wait_idle();
    int k;
    k = 0;
    while (cpu_busy_o && k < 40) begin
      cpu_req_i   = $urandom_range(0, 1);
      cpu_addr_i  = $urandom;
      cpu_wdata_i = $urandom;
      cpu_we_i    = $urandom_range(0, 1);
      cpu_sel_i   = 4'($urandom);
      @(negedge clk_i);
      k++;
    end
    if (cpu_busy_o) begin
      n_vec++; n_fail++;
      $display("FAIL busy_timeout: got busy=1 after 40 cycles, expected 0");
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [3:0] s, input int dly, input logic [31:0] sd);
    txn_t t;
    wait_idle();
    cpu_req_i   = 1'b1;
    cpu_addr_i  = a;
    cpu_wdata_i = d;
    cpu_we_i    = w;
    cpu_sel_i   = s;
    slave_delay = dly;
    slave_data  = sd;
    t.addr = a; t.wdata = d; t.we = w; t.sel = s;
    t.delay = dly; t.sdata = sd; t.req_edge = cycle + 1;
    expq.push_back(t);
    @(negedge clk_i);
    cpu_req_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n_i = 1'b0;
    cpu_req_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0; cpu_we_i = 1'b0; cpu_sel_i = 4'h0;
    repeat (3) @(negedge clk_i);
    // Reset state
    chk("rst_busy", {31'd0, cpu_busy_o}, 32'd0);
    chk("rst_rvalid", {31'd0, cpu_rvalid_o}, 32'd0);
    chk("rst_rdata", cpu_rdata_o, 32'd0);
    chk("rst_err", {31'd0, cpu_err_o}, 32'd0);
    chk("rst_addr", wb_addr_o, 32'd0);
    chk("rst_data", wb_data_o, 32'd0);
    chk("rst_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    #1 rst_n_i = 1'b1;
    @(negedge clk_i);

    // Directed: write, read, back-to-back reads, timeout, ACK on last allowed cycle.
    issue(32'h1000_0040, 32'hDEAD_BEEF, 1'b1, 4'hF, 2, 32'h1234_5678);
    issue(32'h1000_0004, 32'h0, 1'b0, 4'hF, 2, 32'h0000_00A5);
    issue(32'h1000_0008, 32'h0, 1'b0, 4'hF, 2, 32'h0000_1111);
    issue(32'h1000_000C, 32'h0, 1'b0, 4'hF, 2, 32'h0000_2222);
    wait_idle();
    chk("b2b_interval", rise_last - rise_prev, 32'd4);
    issue(32'h2000_0000, 32'h0, 1'b0, 4'h3, 0, 32'hFFFF_FFFF);
    issue(32'h2000_0010, 32'h0, 1'b0, 4'hC, T, 32'hCAFE_F00D);
    issue(32'h2000_0020, 32'h0, 1'b0, 4'h1, T + 1, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of a bus cycle.
    issue(32'h3000_0000, 32'h0, 1'b0, 4'hF, 0, 32'h0);
    @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("async_rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("async_rst_busy", {31'd0, cpu_busy_o}, 32'd0);
    chk("async_rst_rvalid", {31'd0, cpu_rvalid_o}, 32'd0);
    expq.delete();
    @(negedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (12) @(negedge clk_i);
    issue(32'h3000_0004, 32'h0, 1'b0, 4'hF, 3, 32'h5A5A_5A5A);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 3);
      if (k == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom),
            $urandom_range(0, T + 3), $urandom);
    end

    wait_idle();
    k = 0;
    while (expq.size() != 0 && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    if (expq.size() != 0) begin
      n_vec++; n_fail++;
      $display("FAIL drain: got %0d pending completions, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
